// File: rtl/st_skid_reg.sv
// Ready-path register slice: two-entry skid buffer with a flopped upstream
// ready, start-of-packet tracking and optional per-packet tuser hold.
module st_skid_reg #(
    parameter int TUSER_WIDTH = 128,
    parameter int TDATA_WIDTH = 256,
    parameter bit TUSER_HOLD  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   axis_tvalid,
    input  logic                   axis_tlast,
    input  logic [TUSER_WIDTH-1:0] axis_tuser,
    input  logic [TDATA_WIDTH-1:0] axis_tdata,
    output logic                   axis_tready,
    output logic                   axis_reg_tvalid,
    output logic                   axis_reg_tlast,
    output logic [TUSER_WIDTH-1:0] axis_reg_tuser,
    output logic [TDATA_WIDTH-1:0] axis_reg_tdata,
    output logic                   axis_reg_sop,
    input  logic                   axis_reg_tready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    typedef struct packed {
        logic                   tlast;
        logic [TUSER_WIDTH-1:0] tuser;
        logic [TDATA_WIDTH-1:0] tdata;
        logic                   sop;
    } beat_t;

    state_t                 state_q;
    state_t                 state_d;
    beat_t                  main_q;
    beat_t                  main_d;
    beat_t                  skid_q;
    beat_t                  skid_d;
    beat_t                  in_beat_s;
    logic                   tready_q;
    logic                   tready_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   sop_trk_q;
    logic                   sop_trk_d;
    logic [TUSER_WIDTH-1:0] held_tuser_q;
    logic [TUSER_WIDTH-1:0] held_tuser_d;
    logic                   in_fire_s;
    logic                   out_fire_s;

    assign in_fire_s  = axis_tvalid & tready_q;
    assign out_fire_s = valid_q & axis_reg_tready;

    // Assemble the incoming beat, tagging it with sop and the tuser it carries
    always_comb begin
        in_beat_s.tlast = axis_tlast;
        in_beat_s.tdata = axis_tdata;
        in_beat_s.sop   = sop_trk_q;
        in_beat_s.tuser = axis_tuser;
        if (TUSER_HOLD) begin
            // The sop beat carries its own tuser; later beats reuse the captured one
            if (sop_trk_q) begin
                in_beat_s.tuser = axis_tuser;
            end else begin
                in_beat_s.tuser = held_tuser_q;
            end
        end else begin
            in_beat_s.tuser = axis_tuser;
        end
    end

    // Packet-boundary tracker and first-beat tuser capture
    always_comb begin
        sop_trk_d    = sop_trk_q;
        held_tuser_d = held_tuser_q;
        if (in_fire_s) begin
            sop_trk_d = axis_tlast;
        end else begin
            sop_trk_d = sop_trk_q;
        end
        if (in_fire_s && sop_trk_q) begin
            held_tuser_d = axis_tuser;
        end else begin
            held_tuser_d = held_tuser_q;
        end
    end

    // Next-state and entry-update logic for the two-entry buffer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_d = ST_BUSY;
                    main_d  = in_beat_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (in_fire_s && !out_fire_s) begin
                    state_d = ST_FULL;
                    skid_d  = in_beat_s;
                end else if (in_fire_s && out_fire_s) begin
                    state_d = ST_BUSY;
                    main_d  = in_beat_s;
                end else if (out_fire_s) begin
                    // Clearing main keeps the gated outputs coming straight from flops
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (out_fire_s) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                    skid_d  = '0;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        valid_d  = (state_d != ST_EMPTY);
        tready_d = (state_d != ST_FULL);
    end

    // State, entry and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            tready_q     <= 1'b0;
            valid_q      <= 1'b0;
            sop_trk_q    <= 1'b1;
            held_tuser_q <= '0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            tready_q     <= tready_d;
            valid_q      <= valid_d;
            sop_trk_q    <= sop_trk_d;
            held_tuser_q <= held_tuser_d;
        end
    end

    assign axis_tready     = tready_q;
    assign axis_reg_tvalid = valid_q;
    assign axis_reg_tlast  = main_q.tlast;
    assign axis_reg_tuser  = main_q.tuser;
    assign axis_reg_tdata  = main_q.tdata;
    assign axis_reg_sop    = main_q.sop;

endmodule

// File: tb/tb_st_skid_reg.sv
// Directed bench for st_skid_reg: vector table plus hand-written sequences for
// tuser hold and reset while full. Two instances: per-beat and held tuser.
module tb_st_skid_reg;

    localparam int TU = 8;
    localparam int TD = 16;

    typedef struct packed {
        logic          tready;
        logic          vld;
        logic          tl;
        logic [TU-1:0] tu;
        logic [TD-1:0] td;
        logic          sop;
    } out_t;

    typedef struct {
        logic          tv;
        logic          tl;
        logic [TU-1:0] tu;
        logic [TD-1:0] td;
        logic          rr;
        out_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tvalid, tlast, reg_tready;
    logic [TU-1:0] tuser;
    logic [TD-1:0] tdata;

    logic          tready0, vld0, tl0, sop0;
    logic [TU-1:0] tu0;
    logic [TD-1:0] td0;
    logic          tready1, vld1, tl1, sop1;
    logic [TU-1:0] tu1;
    logic [TD-1:0] td1;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    st_skid_reg #(.TUSER_WIDTH(TU), .TDATA_WIDTH(TD), .TUSER_HOLD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .axis_tvalid(tvalid), .axis_tlast(tlast), .axis_tuser(tuser), .axis_tdata(tdata),
        .axis_tready(tready0),
        .axis_reg_tvalid(vld0), .axis_reg_tlast(tl0), .axis_reg_tuser(tu0),
        .axis_reg_tdata(td0), .axis_reg_sop(sop0), .axis_reg_tready(reg_tready)
    );

    st_skid_reg #(.TUSER_WIDTH(TU), .TDATA_WIDTH(TD), .TUSER_HOLD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .axis_tvalid(tvalid), .axis_tlast(tlast), .axis_tuser(tuser), .axis_tdata(tdata),
        .axis_tready(tready1),
        .axis_reg_tvalid(vld1), .axis_reg_tlast(tl1), .axis_reg_tuser(tu1),
        .axis_reg_tdata(td1), .axis_reg_sop(sop1), .axis_reg_tready(reg_tready)
    );

    function automatic out_t mk(input logic rdy, input logic v, input logic l,
                                input logic [TU-1:0] u, input logic [TD-1:0] d,
                                input logic s);
        out_t o;
        o.tready = rdy; o.vld = v; o.tl = l; o.tu = u; o.td = d; o.sop = s;
        return o;
    endfunction

    function automatic out_t act0();
        return mk(tready0, vld0, tl0, tu0, td0, sop0);
    endfunction

    function automatic out_t act1();
        return mk(tready1, vld1, tl1, tu1, td1, sop1);
    endfunction

    task automatic add(input logic v, input logic l, input logic [TU-1:0] u,
                       input logic [TD-1:0] d, input logic r, input out_t e);
        vec_t x;
        x.tv = v; x.tl = l; x.tu = u; x.td = d; x.rr = r; x.exp = e;
        tbl.push_back(x);
    endtask

    task automatic check(input string nm, input out_t a, input out_t e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got tready=%b vld=%b tlast=%b tuser=%h tdata=%h sop=%b, expected tready=%b vld=%b tlast=%b tuser=%h tdata=%h sop=%b",
                     nm, a.tready, a.vld, a.tl, a.tu, a.td, a.sop,
                     e.tready, e.vld, e.tl, e.tu, e.td, e.sop);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [TU-1:0] u,
                         input logic [TD-1:0] d, input logic r);
        tvalid = v; tlast = l; tuser = u; tdata = d; reg_tready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);

        // Single beat, then drain
        add(1'b1, 1'b1, 8'h03, 16'h00A5, 1'b1, mk(1'b1, 1'b1, 1'b1, 8'h03, 16'h00A5, 1'b1));
        add(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));
        // Streaming 8 beats at full rate
        for (int i = 1; i <= 8; i++) begin
            add(1'b1, (i == 8), 8'(i), 16'(i), 1'b1,
                mk(1'b1, 1'b1, (i == 8), 8'(i), 16'(i), (i == 1)));
        end
        add(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));
        // Backpressure: fill both entries, beat 3 held upstream, then drain in order
        add(1'b1, 1'b0, 8'h01, 16'h0001, 1'b0, mk(1'b1, 1'b1, 1'b0, 8'h01, 16'h0001, 1'b1));
        add(1'b1, 1'b0, 8'h02, 16'h0002, 1'b0, mk(1'b0, 1'b1, 1'b0, 8'h01, 16'h0001, 1'b1));
        add(1'b1, 1'b1, 8'h03, 16'h0003, 1'b0, mk(1'b0, 1'b1, 1'b0, 8'h01, 16'h0001, 1'b1));
        add(1'b1, 1'b1, 8'h03, 16'h0003, 1'b1, mk(1'b1, 1'b1, 1'b0, 8'h02, 16'h0002, 1'b0));
        add(1'b1, 1'b1, 8'h03, 16'h0003, 1'b1, mk(1'b1, 1'b1, 1'b1, 8'h03, 16'h0003, 1'b0));
        add(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));
        // Simultaneous in/out fire while BUSY
        add(1'b1, 1'b1, 8'h10, 16'h0010, 1'b0, mk(1'b1, 1'b1, 1'b1, 8'h10, 16'h0010, 1'b1));
        add(1'b1, 1'b1, 8'h11, 16'h0011, 1'b1, mk(1'b1, 1'b1, 1'b1, 8'h11, 16'h0011, 1'b1));
        add(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        check("reset0", act0(), mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));
        check("reset1", act1(), mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", act0(), mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));

        foreach (tbl[i]) begin
            drive(tbl[i].tv, tbl[i].tl, tbl[i].tu, tbl[i].td, tbl[i].rr);
            tick();
            check($sformatf("vec%0d", i), act0(), tbl[i].exp);
        end

        // Held tuser: 3-beat packet then a single-beat packet
        drive(1'b1, 1'b0, 8'h07, 16'h0021, 1'b1); tick();
        check("hold_b1_per", act0(), mk(1'b1, 1'b1, 1'b0, 8'h07, 16'h0021, 1'b1));
        check("hold_b1",     act1(), mk(1'b1, 1'b1, 1'b0, 8'h07, 16'h0021, 1'b1));
        drive(1'b1, 1'b0, 8'h09, 16'h0022, 1'b1); tick();
        check("hold_b2_per", act0(), mk(1'b1, 1'b1, 1'b0, 8'h09, 16'h0022, 1'b0));
        check("hold_b2",     act1(), mk(1'b1, 1'b1, 1'b0, 8'h07, 16'h0022, 1'b0));
        drive(1'b1, 1'b1, 8'h0B, 16'h0023, 1'b1); tick();
        check("hold_b3_per", act0(), mk(1'b1, 1'b1, 1'b1, 8'h0B, 16'h0023, 1'b0));
        check("hold_b3",     act1(), mk(1'b1, 1'b1, 1'b1, 8'h07, 16'h0023, 1'b0));
        drive(1'b1, 1'b1, 8'h02, 16'h0024, 1'b1); tick();
        check("hold_b4",     act1(), mk(1'b1, 1'b1, 1'b1, 8'h02, 16'h0024, 1'b1));
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1); tick();
        check("hold_idle",   act1(), mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));

        // Reset while FULL and mid-packet
        drive(1'b1, 1'b0, 8'h31, 16'h0031, 1'b0); tick();
        drive(1'b1, 1'b0, 8'h32, 16'h0032, 1'b0); tick();
        check("full_before_rst", act0(), mk(1'b0, 1'b1, 1'b0, 8'h31, 16'h0031, 1'b1));
        rst_n = 1'b0;
        #1;
        check("rst_async0", act0(), mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));
        check("rst_async1", act1(), mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        check("rdy_after_rst2", act0(), mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));
        drive(1'b1, 1'b0, 8'h40, 16'h0040, 1'b1); tick();
        check("sop_after_rst0", act0(), mk(1'b1, 1'b1, 1'b0, 8'h40, 16'h0040, 1'b1));
        check("sop_after_rst1", act1(), mk(1'b1, 1'b1, 1'b0, 8'h40, 16'h0040, 1'b1));
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1); tick();
        check("final_idle", act0(), mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/st_skid_reg.md
Name: st_skid_reg

Overview:
- Axis-like register slice that registers the backward (ready) path, the opposite direction to a forward-valid register slice.
- Two-entry skid buffer: axis_tready comes straight from a flop, cutting the combinational ready chain from the downstream consumer to the upstream producer.
- Tracks packet boundaries: flags start-of-packet on the output and can hold the first beat's tuser for a whole packet.
- Used between PCIe-interface stages where ready timing closure fails.

Parameters:
TUSER_WIDTH, 128, width of axis_tuser / axis_reg_tuser
TDATA_WIDTH, 256, width of axis_tdata / axis_reg_tdata
TUSER_HOLD, 0, 1 = output tuser is the first beat's tuser for every beat of the packet; 0 = per-beat tuser

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
axis_tvalid  input  1  upstream beat valid
axis_tlast  input  1  upstream last beat of packet
axis_tuser  input  TUSER_WIDTH  upstream sideband
axis_tdata  input  TDATA_WIDTH  upstream data
axis_tready  output  1  upstream ready, driven directly by a flop
axis_reg_tvalid  output  1  downstream valid
axis_reg_tlast  output  1  downstream last
axis_reg_tuser  output  TUSER_WIDTH  downstream sideband
axis_reg_tdata  output  TDATA_WIDTH  downstream data
axis_reg_sop  output  1  current output beat is the first beat of a packet
axis_reg_tready  input  1  downstream ready

Behaviour:
- Reset (async assert, sync release): state EMPTY; axis_tready=0; axis_reg_tvalid=0; axis_reg_sop=0; internal sop tracker=1; held tuser=0. axis_tready rises on the first clk edge after rst_n deasserts.
- Storage: main entry (drives outputs) and skid entry; each holds {tlast, tuser, tdata, sop}.
- Handshake events: in_fire = axis_tvalid & axis_tready; out_fire = axis_reg_tvalid & axis_reg_tready.
- States and transitions:
  - EMPTY: in_fire -> BUSY; beat loaded into main.
  - BUSY: in_fire & !out_fire -> FULL; beat loaded into skid.
  - BUSY: in_fire & out_fire -> BUSY; main reloaded with the new beat.
  - BUSY: !in_fire & out_fire -> EMPTY.
  - FULL: out_fire -> BUSY; skid moves to main. in_fire is impossible in FULL.
- Ready: axis_tready register next-value = (next_state != FULL). It is 1 in EMPTY/BUSY and 0 in FULL. It never depends combinationally on axis_reg_tready.
- Output validity: axis_reg_tvalid = state != EMPTY.
- Latency and throughput: 1 cycle from in_fire to axis_reg_tvalid when EMPTY. Sustained 1 beat/cycle when the consumer is always ready. No beat is dropped or duplicated; order is preserved.
- Output gating: axis_reg_tlast, axis_reg_tuser, axis_reg_tdata and axis_reg_sop are forced to 0 whenever axis_reg_tvalid=0.
- Stability: while axis_reg_tvalid=1 and axis_reg_tready=0, all outputs are held stable.
- SOP tracker: a beat's sop = tracker value at its in_fire. Tracker is set to 1 on in_fire with tlast=1, and cleared to 0 on in_fire with tlast=0. A single-beat packet has sop=1 and tlast=1.
- TUSER_HOLD=1: on an in_fire with sop=1, capture tuser into the held register. Every stored beat carries the held value (the new value on its sop beat). Non-sop input tuser is ignored.
- Upstream protocol: axis_tvalid may be asserted while axis_tready=0; no transfer occurs. Upstream must hold the beat, but the block does not check this.
- Reset mid-packet: both entries are discarded and the tracker returns to 1. The next accepted beat is treated as sop.

Test Plan:
- Single beat: tvalid=1, tlast=1, tdata=0xA5, tuser=0x3 with reg_tready=1 -> next cycle reg_tvalid=1, tdata=0xA5, sop=1, tlast=1; the following cycle reg_tvalid=0 and data outputs=0.
- Streaming: 8 back-to-back beats, tdata=1..8, tlast on beat 8, reg_tready=1 -> output 1..8 on consecutive cycles; tready stays 1; sop only on beat 1.
- Backpressure: reg_tready=0 while sending beats 1,2,3 -> beats 1 and 2 accepted, tready falls after beat 2, beat 3 held upstream. reg_tready=1 -> outputs 1,2,3 in order; tready returns to 1 the cycle after the first out_fire.
- Simultaneous: BUSY holding beat 0x10, in_fire(0x11) and out_fire in the same cycle -> state stays BUSY; next output is 0x11; no skid use.
- TUSER_HOLD=1: 3-beat packet with tuser 0x7, 0x9, 0xB then 1-beat packet with tuser 0x2 -> output tuser 0x7, 0x7, 0x7, 0x2; sop=1,0,0,1.
- Reset in FULL: assert rst_n=0 -> tready=0 and reg_tvalid=0 immediately. After release, tready=1 one cycle later; the first new beat has sop=1.
